// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/
//                REMU in the EX stage. Operands are latched at start, one
//                quotient bit is produced per cycle, and divide-by-zero and
//                signed overflow finish in a single cycle. div_done_e tells
//                the hazard unit when the EX stage may advance.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                div_en_e              - EX instruction is a divide
//                div_op_e[1:0]         - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//                op_a_e, op_b_e        - forwarded dividend / divisor
//                hold_e                - EX frozen by another stall
//                flush                 - kill any operation in progress
//                div_done_e            - result valid (registered)
//                div_result_e          - quotient or remainder
//                div_busy              - iterating
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_en_e,
    input  logic [1:0]      div_op_e,
    input  logic [XLEN-1:0] op_a_e,
    input  logic [XLEN-1:0] op_b_e,
    input  logic            hold_e,
    input  logic            flush,
    output logic            div_done_e,
    output logic [XLEN-1:0] div_result_e,
    output logic            div_busy
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(XLEN - 1);

    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;       // holds |a| at start, shifts out as quotient shifts in
    logic [XLEN-1:0]  r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_op_rem;
    logic             r_en_lost;   // en dropped mid-operation: finish silently
    logic             r_done;
    logic [XLEN-1:0]  r_result;

    // ------------------------------------------------------------------
    // Operand preparation for the start cycle
    // ------------------------------------------------------------------
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_res;

    assign w_signed   = ~div_op_e[0];
    assign w_a_neg    = w_signed & op_a_e[XLEN-1];
    assign w_b_neg    = w_signed & op_b_e[XLEN-1];
    assign w_a_abs    = w_a_neg ? (~op_a_e + 1'b1) : op_a_e;
    assign w_b_abs    = w_b_neg ? (~op_b_e + 1'b1) : op_b_e;
    assign w_div_zero = (op_b_e == '0);
    assign w_ovf      = w_signed & (op_a_e == c_INT_MIN) & (op_b_e == '1);

    // Divide-by-zero: Q = all ones, R = a. Overflow: Q = INT_MIN (= a), R = 0.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = div_op_e[1] ? op_a_e : '1;
        end else begin
            w_special_res = div_op_e[1] ? '0 : op_a_e;
        end
    end

    // ------------------------------------------------------------------
    // One restoring step. The shifted remainder needs XLEN+1 bits because
    // an unsigned divisor can have its MSB set.
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_final;

    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
    // Only used when w_ge, so the difference always fits in XLEN bits.
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_divisor;
    assign w_rem_nx = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

    always_comb begin
        w_final = '0;
        if (r_op_rem) begin
            w_final = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
        end else begin
            w_final = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_op_rem  <= 1'b0;
            r_en_lost <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else if (flush) begin
            r_state <= c_ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (div_en_e) begin
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= c_ST_DONE;
                        end else begin
                            r_quo     <= w_a_abs;
                            r_divisor <= w_b_abs;
                            r_rem     <= '0;
                            r_cnt     <= '0;
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                            r_op_rem  <= div_op_e[1];
                            r_en_lost <= 1'b0;
                            r_state   <= c_ST_BUSY;
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!div_en_e) begin
                        r_en_lost <= 1'b1;
                    end
                    if (r_cnt == c_LAST_STEP) begin
                        if (r_en_lost || !div_en_e) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    // Leaving DONE returns to IDLE, so the en still high in
                    // this cycle cannot restart the same instruction.
                    if (!hold_e) begin
                        r_done  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign div_done_e   = r_done;
    assign div_result_e = r_result;
    assign div_busy     = (r_state == c_ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_en_e;
    logic [1:0]  div_op_e;
    logic [31:0] op_a_e;
    logic [31:0] op_b_e;
    logic        hold_e;
    logic        flush;
    logic        div_done_e;
    logic [31:0] div_result_e;
    logic        div_busy;

    int checks;
    int failures;

    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_en_e     (div_en_e),
        .div_op_e     (div_op_e),
        .op_a_e       (op_a_e),
        .op_b_e       (op_b_e),
        .hold_e       (hold_e),
        .flush        (flush),
        .div_done_e   (div_done_e),
        .div_result_e (div_result_e),
        .div_busy     (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a divide in the current (IDLE) cycle, wait for done, check the
    // cycle count from start and the result. Leaves the DUT in its DONE cycle.
    task automatic run_div(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input int exp_lat, input string name);
        int lat;
        lat      = 0;
        div_en_e = 1'b1;
        div_op_e = op;
        op_a_e   = a;
        op_b_e   = b;
        while (lat < 40 && div_done_e !== 1'b1) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (div_result_e !== exp_res) begin
            failures++;
            $display("FAIL %s result: got 0x%08h, expected 0x%08h", name, div_result_e, exp_res);
        end
    endtask

    // Let EX advance out of DONE with en still high, then drop en.
    task automatic end_div(input string name);
        tick();
        checks++;
        if (div_done_e !== 1'b0 || div_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s exit: done=%b busy=%b, expected done=0 busy=0", name, div_done_e, div_busy);
        end
        div_en_e = 1'b0;
        tick();
        checks++;
        if (div_busy !== 1'b0 || div_done_e !== 1'b0) begin
            failures++;
            $display("FAIL %s restart: done=%b busy=%b, expected done=0 busy=0", name, div_done_e, div_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (div_done_e !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b, expected 0", div_done_e);
        end
        checks++;
        if (div_result_e !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got 0x%08h, expected 0x00000000", div_result_e);
        end
        checks++;
        if (div_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b, expected 0", div_busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        run_div(c_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        end_div("divu_100_7");
        run_div(c_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
        end_div("remu_100_7");
        // Divisor with MSB set exercises the XLEN+1-bit compare.
        run_div(c_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33, "divu_big");
        end_div("divu_big");
        run_div(c_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, "remu_big");
        end_div("remu_big");
    endtask

    task automatic test_signed();
        run_div(c_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
        end_div("div_m7_2");
        run_div(c_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
        end_div("rem_m7_2");
        run_div(c_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
        end_div("rem_7_m2");
        run_div(c_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
        end_div("div_7_m2");
    endtask

    task automatic test_special();
        run_div(c_DIV, 32'd55, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
        end_div("div_by_zero");
        run_div(c_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, "remu_by_zero");
        end_div("remu_by_zero");
        run_div(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        end_div("div_ovf");
        run_div(c_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
        end_div("rem_ovf");
    endtask

    task automatic test_flush();
        div_en_e = 1'b1;
        div_op_e = c_DIVU;
        op_a_e   = 32'd1000;
        op_b_e   = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (div_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre_busy: got %b, expected 1", div_busy);
        end
        flush = 1'b1;
        tick();
        checks++;
        if (div_done_e !== 1'b0 || div_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: done=%b busy=%b, expected done=0 busy=0", div_done_e, div_busy);
        end
        flush    = 1'b0;
        div_en_e = 1'b0;
        tick();
        checks++;
        if (div_done_e !== 1'b0 || div_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_after: done=%b busy=%b, expected done=0 busy=0", div_done_e, div_busy);
        end
        run_div(c_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_9_3");
        end_div("divu_9_3");
        // Flush while sitting in DONE under hold must drop done.
        run_div(c_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_zero");
        hold_e = 1'b1;
        flush  = 1'b1;
        tick();
        checks++;
        if (div_done_e !== 1'b0) begin
            failures++;
            $display("FAIL flush_done: got done=%b, expected 0", div_done_e);
        end
        hold_e   = 1'b0;
        flush    = 1'b0;
        div_en_e = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        run_div(c_DIVU, 32'd100, 32'd7, 32'd14, 33, "hold_divu");
        hold_e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (div_done_e !== 1'b1 || div_result_e !== 32'd14 || div_busy !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: done=%b busy=%b result=0x%08h, expected done=1 busy=0 result=0x0000000e",
                         i, div_done_e, div_busy, div_result_e);
            end
        end
        hold_e = 1'b0;
        end_div("hold_divu");
    endtask

    task automatic test_back_to_back();
        run_div(c_DIVU, 32'd50, 32'd5, 32'd10, 33, "b2b_first");
        // EX advances; the next divide sits in EX with en still high.
        tick();
        checks++;
        if (div_done_e !== 1'b0 || div_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: done=%b busy=%b, expected done=0 busy=0", div_done_e, div_busy);
        end
        run_div(c_DIVU, 32'd81, 32'd9, 32'd9, 33, "b2b_second");
        end_div("b2b_second");
    endtask

    task automatic test_rst_mid();
        div_en_e = 1'b1;
        div_op_e = c_DIVU;
        op_a_e   = 32'd50;
        op_b_e   = 32'd5;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (div_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre_busy: got %b, expected 1", div_busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (div_done_e !== 1'b0 || div_busy !== 1'b0 || div_result_e !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid: done=%b busy=%b result=0x%08h, expected all 0",
                     div_done_e, div_busy, div_result_e);
        end
        rst      = 1'b0;
        div_en_e = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (div_done_e !== 1'b0 || div_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after: done=%b busy=%b, expected done=0 busy=0", div_done_e, div_busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        div_en_e = 1'b0;
        div_op_e = 2'b00;
        op_a_e   = 32'h0;
        op_b_e   = 32'h0;
        hold_e   = 1'b0;
        flush    = 1'b0;

        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_hold();
        test_back_to_back();
        test_rst_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
